// File: rtl/sfifo_pkg.sv
// sfifo_pkg: geometry helpers shared by the width-converting FIFO.
// Default localparams describe the stock 18->18, 1K-unit build.
package sfifo_pkg;
   localparam int DEF_WR_W = 18;
   localparam int DEF_RD_W = 18;
   localparam int DEF_AW   = 10;

   function automatic int narrow_w(input int wr, input int rd);
      return (wr < rd) ? wr : rd;
   endfunction

   function automatic int wconv_ratio(input int wr, input int rd);
      return (wr > rd) ? wr / rd : rd / wr;
   endfunction

   localparam int NARROW_W = narrow_w(DEF_WR_W, DEF_RD_W);
   localparam int WR_UNITS = DEF_WR_W / NARROW_W;
   localparam int RD_UNITS = DEF_RD_W / NARROW_W;
   localparam int DEPTH    = 1 << DEF_AW;

   typedef logic [DEF_AW:0] count_t;
endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: simple dual-port RAM, per-lane write enables, registered read.
// A same-row write is forwarded lane by lane into the read register.
module sfifo_ram
   import sfifo_pkg::*;
#(
   parameter int UNIT_W = 18,
   parameter int LANES  = 1,
   parameter int AW     = 10
) (
   input  logic                    clk,
   input  logic [LANES-1:0]        we,
   input  logic [AW-1:0]           waddr,
   input  logic [UNIT_W*LANES-1:0] wdata,
   input  logic                    re,
   input  logic [AW-1:0]           raddr,
   output logic [UNIT_W*LANES-1:0] rdata
);

   logic [UNIT_W*LANES-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i])
            mem[waddr][i*UNIT_W +: UNIT_W] <= wdata[i*UNIT_W +: UNIT_W];
         if (re)
            rdata[i*UNIT_W +: UNIT_W] <= (we[i] && waddr == raddr) ?
               wdata[i*UNIT_W +: UNIT_W] : mem[raddr][i*UNIT_W +: UNIT_W];
      end
   end

endmodule

// File: rtl/sfifo_wconv.sv
// sfifo_wconv: single-clock FIFO with 1/2/4 width conversion,
// watermarks, error pulses, synchronous flush and optional FWFT.
module sfifo_wconv
   import sfifo_pkg::*;
#(
   parameter int          WR_DATA_WIDTH = DEF_WR_W,
   parameter int          RD_DATA_WIDTH = DEF_RD_W,
   parameter int          ADDR_WIDTH    = DEF_AW,
   parameter logic [10:0] UPAE_DBITS    = 11'd10,
   parameter logic [10:0] UPAF_DBITS    = 11'd10,
   parameter int          FWFT          = 0
) (
   input  logic                     clock0,
   input  logic                     RESET_N,
   input  logic                     Flush,
   input  logic                     PUSH,
   input  logic [WR_DATA_WIDTH-1:0] DIN,
   input  logic                     POP,
   output logic [RD_DATA_WIDTH-1:0] DOUT,
   output logic                     Full,
   output logic                     Almost_Full,
   output logic                     Full_Watermark,
   output logic                     Empty,
   output logic                     Almost_Empty,
   output logic                     Empty_Watermark,
   output logic                     Overrun_Error,
   output logic                     Underrun_Error
);

   localparam int NW  = narrow_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
   localparam int WU  = WR_DATA_WIDTH / NW;
   localparam int RU  = RD_DATA_WIDTH / NW;
   localparam int MU  = wconv_ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
   localparam int LB  = $clog2(MU);
   localparam int RAW = ADDR_WIDTH - LB;
   localparam int WB  = $clog2(WU);
   localparam int RB  = $clog2(RU);

   typedef logic [ADDR_WIDTH:0]   cnt_t;
   typedef logic [ADDR_WIDTH-1:0] ptr_t;

   localparam ptr_t LMASK   = ptr_t'(MU - 1);
   localparam cnt_t C_WU    = cnt_t'(WU);
   localparam cnt_t C_RU    = cnt_t'(RU);
   localparam cnt_t C_DEPTH = cnt_t'(2**ADDR_WIDTH);

   cnt_t count, cnt_n, free_n, ram_cnt, avail;
   ptr_t wptr, rptr, wl, rl, rl_q;
   logic ovld, ovld_n, dvld;
   logic push_acc, pop_acc, rd_en;
   logic [MU-1:0] we;
   logic [RAW-1:0] wrow, rrow;
   logic [NW*MU-1:0] q, q_sh;

   always_comb begin
      push_acc = PUSH & ~Full;
      pop_acc  = POP & ~Empty;
      // ovld marks a head word already parked in the RAM read register
      ram_cnt  = count - (ovld ? C_RU : '0);
      avail    = ram_cnt + ((ovld & push_acc) ? C_WU : '0);
      if (FWFT != 0)
         rd_en = !Flush && (ovld ? (pop_acc && avail >= C_RU)
                                 : (ram_cnt >= C_RU));
      else
         rd_en = pop_acc && !Flush;
      ovld_n = ovld;
      if (FWFT == 0 || Flush) ovld_n = 1'b0;
      else if (rd_en)         ovld_n = 1'b1;
      else if (pop_acc)       ovld_n = 1'b0;
      cnt_n = Flush ? '0 : count + (push_acc ? C_WU : '0)
                                 - (pop_acc ? C_RU : '0);
      free_n = C_DEPTH - cnt_n;
      wl   = wptr & LMASK;
      rl   = rptr & LMASK;
      wrow = RAW'(wptr >> LB);
      rrow = RAW'(rptr >> LB);
      for (int i = 0; i < MU; i++)
         we[i] = push_acc && !Flush && (ptr_t'(i) >= wl)
                 && (ptr_t'(i) < wl + ptr_t'(WU));
   end

   sfifo_ram #(
      .UNIT_W (NW),
      .LANES  (MU),
      .AW     (RAW)
   ) u_ram (
      .clk   (clock0),
      .we    (we),
      .waddr (wrow),
      .wdata ({(MU/WU){DIN}}),
      .re    (rd_en),
      .raddr (rrow),
      .rdata (q)
   );

   assign q_sh = q >> (rl_q * NW);
   assign DOUT = dvld ? q_sh[RD_DATA_WIDTH-1:0] : '0;

   always_ff @(posedge clock0 or negedge RESET_N) begin
      if (!RESET_N) begin
         count           <= '0;
         wptr            <= '0;
         rptr            <= '0;
         rl_q            <= '0;
         ovld            <= 1'b0;
         dvld            <= 1'b0;
         Full            <= 1'b0;
         Almost_Full     <= 1'b0;
         Full_Watermark  <= 1'b0;
         Empty           <= 1'b1;
         Almost_Empty    <= 1'b0;
         Empty_Watermark <= 1'b1;
         Overrun_Error   <= 1'b0;
         Underrun_Error  <= 1'b0;
      end else begin
         count           <= cnt_n;
         ovld            <= ovld_n;
         Full            <= free_n < C_WU;
         Almost_Full     <= (free_n >> WB) == cnt_t'(1);
         Full_Watermark  <= (32'(free_n >> WB) <= 32'(UPAF_DBITS));
         Empty           <= (FWFT != 0) ? !ovld_n : (cnt_n < C_RU);
         Almost_Empty    <= (cnt_n >> RB) == cnt_t'(1);
         Empty_Watermark <= (32'(cnt_n >> RB) <= 32'(UPAE_DBITS));
         Overrun_Error   <= PUSH & Full & !Flush;
         Underrun_Error  <= POP & Empty & !Flush;
         if (Flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push_acc) wptr <= wptr + ptr_t'(WU);
            if (rd_en)    rptr <= rptr + ptr_t'(RU);
         end
         if (rd_en) begin
            rl_q <= rl;
            dvld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sfifo_wconv.sv
// tb_sfifo_wconv: scoreboard bench over four FIFO geometries
// (18->18, 18->9, 9->18, 18->18 FWFT) sharing one clock and reset.
module tb_sfifo_wconv;

   logic clock0 = 1'b0;
   logic RESET_N, flush;

   logic push_a, pop_a, full_a, af_a, fwm_a, empty_a, ae_a, ewm_a, ovr_a, und_a;
   logic [17:0] din_a, dout_a;
   logic push_b, pop_b, full_b, af_b, fwm_b, empty_b, ae_b, ewm_b, ovr_b, und_b;
   logic [17:0] din_b;
   logic [8:0]  dout_b;
   logic push_c, pop_c, full_c, af_c, fwm_c, empty_c, ae_c, ewm_c, ovr_c, und_c;
   logic [8:0]  din_c;
   logic [17:0] dout_c;
   logic push_d, pop_d, full_d, af_d, fwm_d, empty_d, ae_d, ewm_d, ovr_d, und_d;
   logic [17:0] din_d, dout_d;

   logic [17:0] sb_a[$], sb_b[$], sb_c[$], sb_d[$];
   logic [17:0] exp_v, last_a, tmp;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clock0 = ~clock0;

   sfifo_wconv #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18), .FWFT(0)) u_a (
      .clock0(clock0), .RESET_N(RESET_N), .Flush(flush),
      .PUSH(push_a), .DIN(din_a), .POP(pop_a), .DOUT(dout_a),
      .Full(full_a), .Almost_Full(af_a), .Full_Watermark(fwm_a),
      .Empty(empty_a), .Almost_Empty(ae_a), .Empty_Watermark(ewm_a),
      .Overrun_Error(ovr_a), .Underrun_Error(und_a));

   sfifo_wconv #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(9), .FWFT(0)) u_b (
      .clock0(clock0), .RESET_N(RESET_N), .Flush(flush),
      .PUSH(push_b), .DIN(din_b), .POP(pop_b), .DOUT(dout_b),
      .Full(full_b), .Almost_Full(af_b), .Full_Watermark(fwm_b),
      .Empty(empty_b), .Almost_Empty(ae_b), .Empty_Watermark(ewm_b),
      .Overrun_Error(ovr_b), .Underrun_Error(und_b));

   sfifo_wconv #(.WR_DATA_WIDTH(9), .RD_DATA_WIDTH(18), .FWFT(0)) u_c (
      .clock0(clock0), .RESET_N(RESET_N), .Flush(flush),
      .PUSH(push_c), .DIN(din_c), .POP(pop_c), .DOUT(dout_c),
      .Full(full_c), .Almost_Full(af_c), .Full_Watermark(fwm_c),
      .Empty(empty_c), .Almost_Empty(ae_c), .Empty_Watermark(ewm_c),
      .Overrun_Error(ovr_c), .Underrun_Error(und_c));

   sfifo_wconv #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18), .FWFT(1)) u_d (
      .clock0(clock0), .RESET_N(RESET_N), .Flush(flush),
      .PUSH(push_d), .DIN(din_d), .POP(pop_d), .DOUT(dout_d),
      .Full(full_d), .Almost_Full(af_d), .Full_Watermark(fwm_d),
      .Empty(empty_d), .Almost_Empty(ae_d), .Empty_Watermark(ewm_d),
      .Overrun_Error(ovr_d), .Underrun_Error(und_d));

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clock0);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RESET_N = 1'b0;
      flush = 1'b0;
      {push_a, pop_a, push_b, pop_b, push_c, pop_c, push_d, pop_d} = '0;
      din_a = '0; din_b = '0; din_c = '0; din_d = '0;
      repeat (3) step;
      RESET_N = 1'b1;
      step;

      check_eq("rst_empty", 32'(empty_a), 32'd1);
      check_eq("rst_ewm",   32'(ewm_a),   32'd1);
      check_eq("rst_ae",    32'(ae_a),    32'd0);
      check_eq("rst_full",  32'(full_a),  32'd0);
      check_eq("rst_af",    32'(af_a),    32'd0);
      check_eq("rst_fwm",   32'(fwm_a),   32'd0);
      check_eq("rst_dout",  32'(dout_a),  32'd0);
      check_eq("rst_ovr",   32'(ovr_a),   32'd0);
      check_eq("rst_und",   32'(und_a),   32'd0);
      check_eq("rst_fwft_empty", 32'(empty_d), 32'd1);

      // fill 18->18 to the brim
      for (int i = 0; i < 1024; i++) begin
         push_a = 1'b1;
         din_a = 18'(i);
         sb_a.push_back(18'(i));
         step;
         check_eq("fill_full",  32'(full_a),  32'(i == 1023));
         check_eq("fill_af",    32'(af_a),    32'(i == 1022));
         check_eq("fill_fwm",   32'(fwm_a),   32'(i >= 1013));
         check_eq("fill_empty", 32'(empty_a), 32'd0);
      end
      din_a = 18'h3FFFF;
      step;
      push_a = 1'b0;
      check_eq("ovr_pulse", 32'(ovr_a),  32'd1);
      check_eq("ovr_full",  32'(full_a), 32'd1);
      step;
      check_eq("ovr_clear", 32'(ovr_a),  32'd0);
      check_eq("ovr_full2", 32'(full_a), 32'd1);
      check_eq("ovr_af",    32'(af_a),   32'd0);

      // drain
      for (int i = 0; i < 1024; i++) begin
         pop_a = 1'b1;
         step;
         exp_v = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
         last_a = exp_v;
         check_eq("drain_dout",  32'(dout_a),  32'(exp_v));
         check_eq("drain_empty", 32'(empty_a), 32'(i == 1023));
      end
      step;
      pop_a = 1'b0;
      check_eq("und_pulse", 32'(und_a),  32'd1);
      check_eq("und_dout",  32'(dout_a), 32'(last_a));
      step;
      check_eq("und_clear", 32'(und_a),  32'd0);

      // 18 -> 9, little-endian unpacking
      tmp = 18'h2A5F3;
      push_b = 1'b1;
      din_b = tmp;
      sb_b.push_back(18'(tmp[8:0]));
      sb_b.push_back(18'(tmp[17:9]));
      step;
      push_b = 1'b0;
      check_eq("n2w_empty", 32'(empty_b), 32'd0);
      pop_b = 1'b1;
      step;
      exp_v = (sb_b.size() != 0) ? sb_b.pop_front() : 'x;
      check_eq("w2n_dout0", 32'(dout_b), 32'(exp_v));
      check_eq("w2n_ae",    32'(ae_b),   32'd1);
      step;
      pop_b = 1'b0;
      exp_v = (sb_b.size() != 0) ? sb_b.pop_front() : 'x;
      check_eq("w2n_dout1", 32'(dout_b),  32'(exp_v));
      check_eq("w2n_empty", 32'(empty_b), 32'd1);

      // 9 -> 18 packing
      push_c = 1'b1;
      din_c = 9'h0AB;
      tmp = 18'(din_c);
      step;
      check_eq("n2w_empty1", 32'(empty_c), 32'd1);
      din_c = 9'h155;
      sb_c.push_back({din_c, tmp[8:0]});
      step;
      push_c = 1'b0;
      check_eq("n2w_empty2", 32'(empty_c), 32'd0);
      pop_c = 1'b1;
      step;
      pop_c = 1'b0;
      exp_v = (sb_c.size() != 0) ? sb_c.pop_front() : 'x;
      check_eq("n2w_dout", 32'(dout_c), 32'(exp_v));

      // FWFT head visibility and push+pop refill
      push_d = 1'b1;
      din_d = 18'd5;
      sb_d.push_back(18'd5);
      step;
      push_d = 1'b0;
      check_eq("fwft_empty1", 32'(empty_d), 32'd1);
      step;
      check_eq("fwft_empty2", 32'(empty_d), 32'd0);
      exp_v = (sb_d.size() != 0) ? sb_d.pop_front() : 'x;
      check_eq("fwft_head", 32'(dout_d), 32'(exp_v));
      push_d = 1'b1;
      pop_d = 1'b1;
      din_d = 18'd6;
      sb_d.push_back(18'd6);
      step;
      push_d = 1'b0;
      pop_d = 1'b0;
      exp_v = (sb_d.size() != 0) ? sb_d.pop_front() : 'x;
      check_eq("fwft_refill", 32'(dout_d),  32'(exp_v));
      check_eq("fwft_empty3", 32'(empty_d), 32'd0);
      check_eq("fwft_ae",     32'(ae_d),    32'd1);
      pop_d = 1'b1;
      step;
      pop_d = 1'b0;
      check_eq("fwft_drain", 32'(empty_d), 32'd1);
      check_eq("fwft_und",   32'(und_d),   32'd0);

      // flush mid-stream with push+pop in the same cycle
      push_a = 1'b1;
      din_a = 18'h1111;
      sb_a.push_back(din_a);
      step;
      din_a = 18'h2222;
      sb_a.push_back(din_a);
      step;
      push_a = 1'b0;
      pop_a = 1'b1;
      step;
      pop_a = 1'b0;
      exp_v = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
      last_a = exp_v;
      check_eq("pre_flush_dout", 32'(dout_a), 32'(exp_v));
      flush = 1'b1;
      push_a = 1'b1;
      pop_a = 1'b1;
      din_a = 18'h3333;
      step;
      flush = 1'b0;
      push_a = 1'b0;
      pop_a = 1'b0;
      sb_a.delete();
      check_eq("flush_empty", 32'(empty_a), 32'd1);
      check_eq("flush_ewm",   32'(ewm_a),   32'd1);
      check_eq("flush_ae",    32'(ae_a),    32'd0);
      check_eq("flush_ovr",   32'(ovr_a),   32'd0);
      check_eq("flush_und",   32'(und_a),   32'd0);
      check_eq("flush_dout",  32'(dout_a),  32'(last_a));
      push_a = 1'b1;
      din_a = 18'h0444;
      sb_a.push_back(din_a);
      step;
      push_a = 1'b0;
      pop_a = 1'b1;
      step;
      pop_a = 1'b0;
      exp_v = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
      check_eq("post_flush_dout", 32'(dout_a), 32'(exp_v));

      // asynchronous reset between edges
      push_a = 1'b1;
      din_a = 18'h0555;
      step;
      push_a = 1'b0;
      check_eq("pre_rst_empty", 32'(empty_a), 32'd0);
      #2 RESET_N = 1'b0;
      #1;
      sb_a.delete();
      check_eq("arst_empty", 32'(empty_a), 32'd1);
      check_eq("arst_ewm",   32'(ewm_a),   32'd1);
      check_eq("arst_ae",    32'(ae_a),    32'd0);
      check_eq("arst_full",  32'(full_a),  32'd0);
      check_eq("arst_af",    32'(af_a),    32'd0);
      check_eq("arst_fwm",   32'(fwm_a),   32'd0);
      check_eq("arst_dout",  32'(dout_a),  32'd0);
      check_eq("arst_dout_d", 32'(dout_d), 32'd0);
      step;
      RESET_N = 1'b1;
      step;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
